// File: rtl/mem_arb.sv
// Memory port arbiter: shares one pmem port between the IFU (read-only) and the LSU (read/write).
// One transaction is in flight at a time. Every output is registered.
module mem_arb #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int LSU_MAX_CONSEC = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ifu_req,
    input  logic [AW-1:0] i_ifu_addr,
    output logic          o_ifu_gnt,
    output logic          o_ifu_rvalid,
    output logic [DW-1:0] o_ifu_rdata,
    input  logic          i_lsu_req,
    input  logic          i_lsu_wen,
    input  logic [AW-1:0] i_lsu_addr,
    input  logic [DW-1:0] i_lsu_wdata,
    input  logic [3:0]    i_lsu_wmask,
    output logic          o_lsu_gnt,
    output logic          o_lsu_rvalid,
    output logic [DW-1:0] o_lsu_rdata,
    output logic          o_lsu_wdone,
    output logic          o_err,
    output logic          o_mem_valid,
    output logic          o_mem_wen,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [3:0]    o_mem_wmask,
    input  logic          i_mem_ready,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int CW = (LSU_MAX_CONSEC > 0) ? $clog2(LSU_MAX_CONSEC + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LSU_MAX_CONSEC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] lsu_cnt;
    logic [TW-1:0] to_cnt;
    logic          owner_lsu;
    logic          grant_ifu, grant_lsu, rsp_hit, rsp_to, rsp_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // The LSU wins ties until it has taken LSU_MAX_CONSEC grants in a row over a waiting IFU.
    always_comb begin
        state_nxt = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        rsp_hit   = 1'b0;
        rsp_to    = 1'b0;
        case (state)
            IDLE: begin
                if (i_lsu_req && (!i_ifu_req || lsu_cnt != CNT_MAX)) begin
                    grant_lsu = 1'b1;
                    state_nxt = REQ;
                end else if (i_ifu_req) begin
                    grant_ifu = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready) state_nxt = o_mem_wen ? IDLE : RESP;
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    rsp_hit   = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    rsp_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_done = rsp_hit | rsp_to;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ifu_gnt    <= 1'b0;
            o_lsu_gnt    <= 1'b0;
            o_ifu_rvalid <= 1'b0;
            o_lsu_rvalid <= 1'b0;
            o_ifu_rdata  <= '0;
            o_lsu_rdata  <= '0;
            o_lsu_wdone  <= 1'b0;
            o_err        <= 1'b0;
            o_mem_valid  <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_wmask  <= '0;
            owner_lsu    <= 1'b0;
            lsu_cnt      <= '0;
            to_cnt       <= '0;
        end else begin
            o_ifu_gnt    <= grant_ifu;
            o_lsu_gnt    <= grant_lsu;
            o_lsu_wdone  <= (state == REQ) && i_mem_ready && o_mem_wen;
            o_ifu_rvalid <= rsp_done && !owner_lsu;
            o_lsu_rvalid <= rsp_done && owner_lsu;
            o_err        <= rsp_to;

            if (grant_ifu || grant_lsu) begin
                owner_lsu   <= grant_lsu;
                o_mem_valid <= 1'b1;
                o_mem_wen   <= grant_lsu & i_lsu_wen;
                o_mem_addr  <= grant_lsu ? i_lsu_addr : i_ifu_addr;
                o_mem_wdata <= grant_lsu ? i_lsu_wdata : '0;
                o_mem_wmask <= (grant_lsu && i_lsu_wen) ? i_lsu_wmask : 4'h0;
                // Only LSU wins taken over a waiting IFU count toward its starvation limit.
                if (grant_lsu && i_ifu_req) begin
                    if (lsu_cnt != CNT_MAX) lsu_cnt <= lsu_cnt + 1'b1;
                end else begin
                    lsu_cnt <= '0;
                end
            end

            if (state == REQ && i_mem_ready) begin
                o_mem_valid <= 1'b0;
                to_cnt      <= '0;
            end

            if (state == RESP && !rsp_done && to_cnt != '1) to_cnt <= to_cnt + 1'b1;

            // A timed-out read returns zero data to its owner.
            if (rsp_done) begin
                if (owner_lsu) o_lsu_rdata <= rsp_hit ? i_mem_rdata : '0;
                else           o_ifu_rdata <= rsp_hit ? i_mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small configurable memory responder.
module tb_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          ifu_req, lsu_req, lsu_wen;
    logic [AW-1:0] ifu_addr, lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          o_ifu_gnt, o_ifu_rvalid, o_lsu_gnt, o_lsu_rvalid, o_lsu_wdone, o_err;
    logic [DW-1:0] o_ifu_rdata, o_lsu_rdata;
    logic          o_mem_valid, o_mem_wen;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [3:0]    o_mem_wmask;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arb #(.AW(AW), .DW(DW), .LSU_MAX_CONSEC(4), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr),
        .o_ifu_gnt(o_ifu_gnt), .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
        .i_lsu_req(lsu_req), .i_lsu_wen(lsu_wen), .i_lsu_addr(lsu_addr),
        .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
        .o_lsu_wdone(o_lsu_wdone), .o_err(o_err),
        .o_mem_valid(o_mem_valid), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_2468);
    endfunction

    // Memory responder: ready after rdy_wait valid cycles; read data in RESP cycle rsp_gap+1.
    int          rdy_wait = 0;
    int          rsp_gap = 0;
    bit          no_rsp = 1'b0;
    int          vcnt = 0;
    int          rcnt = 0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_word = '0;

    initial begin
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd_word;
                    rd_pend = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (o_mem_valid) begin
                vcnt++;
                if (vcnt > rdy_wait) begin
                    mem_ready = 1'b1;
                    if (!o_mem_wen && !no_rsp) begin
                        rd_pend = 1'b1;
                        rcnt = rsp_gap;
                        rd_word = word(o_mem_addr);
                    end
                end
            end else begin
                vcnt = 0;
            end
        end
    end

    // Event monitor
    int          ifu_rv_n = 0, lsu_rv_n = 0, lsu_gnt_n = 0, wdone_n = 0, err_n = 0;
    logic [31:0] ifu_last = '0, lsu_last = '0;
    bit          gnt_log[$];

    always @(negedge clk) begin
        if (o_ifu_gnt) gnt_log.push_back(1'b0);
        if (o_lsu_gnt) begin
            gnt_log.push_back(1'b1);
            lsu_gnt_n++;
        end
        if (o_ifu_rvalid) begin
            ifu_rv_n++;
            ifu_last = o_ifu_rdata;
        end
        if (o_lsu_rvalid) begin
            lsu_rv_n++;
            lsu_last = o_lsu_rdata;
        end
        if (o_lsu_wdone) wdone_n++;
        if (o_err) err_n++;
    end

    task automatic wait_pulse(input int which, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((which == 0 && o_ifu_rvalid) || (which == 1 && o_lsu_rvalid) ||
                (which == 2 && o_lsu_wdone)) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) chk($sformatf("wait_pulse%0d_expired", which), 1, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        rd_pend = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {o_ifu_gnt, o_ifu_rvalid, o_lsu_gnt, o_lsu_rvalid, o_lsu_wdone, o_err,
                           o_mem_valid, o_mem_wen, o_mem_wmask}, '0);
        chk({tag, "_dat"}, {o_ifu_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          base;
        logic [9:0]  ord_obs, ord_exp;
        logic [70:0] hold_exp;

        i_rst = 1'b1;
        ifu_req = 1'b0; ifu_addr = '0;
        lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        do_reset();
        chk_zero("reset");

        // IFU fetch, 1-cycle grant, memory responds one cycle into RESP
        rdy_wait = 0; rsp_gap = 1;
        ifu_addr = 32'h8000_0000;
        ifu_req = 1'b1;
        @(negedge clk);
        chk("t1_gnt", {o_ifu_gnt, o_lsu_gnt}, 2'b10);
        chk("t1_mem", {o_mem_valid, o_mem_wen, o_mem_wmask, o_mem_addr}, {1'b1, 1'b0, 4'h0, 32'h8000_0000});
        ifu_req = 1'b0;
        wait_pulse(0, cyc);
        chk("t1_lat", cyc, 3);
        chk("t1_rdata", o_ifu_rdata, 32'h0000_0413);
        #1;
        chk("t1_lsu_quiet", lsu_gnt_n + lsu_rv_n + wdone_n, 0);

        // LSU store with ready delayed; fields must hold and wdata is sampled only at grant
        rdy_wait = 3;
        lsu_wen = 1'b1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        lsu_req = 1'b1;
        @(negedge clk);
        chk("t2_gnt", {o_lsu_gnt, o_ifu_gnt}, 2'b10);
        lsu_req = 1'b0;
        lsu_wdata = 32'h0;
        hold_exp = {1'b1, 1'b1, 1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF};
        chk("t2_hold0", {o_mem_valid, o_mem_wen, o_lsu_wdone, o_mem_addr, o_mem_wdata, o_mem_wmask}, hold_exp);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t2_hold%0d", k),
                {o_mem_valid, o_mem_wen, o_lsu_wdone, o_mem_addr, o_mem_wdata, o_mem_wmask}, hold_exp);
        end
        @(negedge clk);
        chk("t2_wdone", {o_mem_valid, o_lsu_wdone, o_lsu_rvalid}, 3'b010);
        @(negedge clk);
        chk("t2_wdone_off", o_lsu_wdone, 1'b0);
        #1;
        chk("t2_wdone_cnt", wdone_n, 1);

        // Both requesters continuously: LSU x4 then IFU, repeating
        do_reset();
        rdy_wait = 0; rsp_gap = 0;
        gnt_log.delete();
        ifu_addr = 32'h8000_0100;
        lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; lsu_wmask = 4'h0;
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (gnt_log.size() >= 10) break;
        end
        ifu_req = 1'b0; lsu_req = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            ord_obs[i] = (i < gnt_log.size()) ? gnt_log[i] : 1'bx;
            ord_exp[i] = (i % 5 != 4);
        end
        chk("t3_order", ord_obs, ord_exp);
        chk("t3_ifu_data", ifu_last, word(32'h8000_0100));
        chk("t3_lsu_data", lsu_last, word(32'h8000_2000));

        // LSU load (mask forced to 0), then a timed-out load, then a normal IFU read
        do_reset();
        base = err_n;
        lsu_wen = 1'b0; lsu_addr = 32'h8000_3000; lsu_wmask = 4'hF;
        lsu_req = 1'b1;
        @(negedge clk);
        chk("t4_ld_req", {o_lsu_gnt, o_mem_valid, o_mem_wen, o_mem_wmask, o_mem_addr},
            {1'b1, 1'b1, 1'b0, 4'h0, 32'h8000_3000});
        lsu_req = 1'b0;
        wait_pulse(1, cyc);
        chk("t4_ld_data", o_lsu_rdata, word(32'h8000_3000));
        no_rsp = 1'b1;
        lsu_addr = 32'h8000_3004;
        lsu_req = 1'b1;
        @(negedge clk);
        lsu_req = 1'b0;
        wait_pulse(1, cyc);
        chk("t4_to_lat", cyc, 9);
        chk("t4_to_resp", {o_err, o_lsu_rdata}, {1'b1, 32'h0});
        no_rsp = 1'b0;
        @(negedge clk);
        chk("t4_err_pulse", o_err, 1'b0);
        ifu_addr = 32'h8000_0200;
        ifu_req = 1'b1;
        @(negedge clk);
        ifu_req = 1'b0;
        wait_pulse(0, cyc);
        chk("t4_after", {o_err, o_ifu_rdata}, {1'b0, word(32'h8000_0200)});
        #1;
        chk("t4_err_cnt", err_n - base, 1);

        // Reset while in RESP; the late rvalid must be ignored
        rsp_gap = 3;
        ifu_addr = 32'h8000_0300;
        ifu_req = 1'b1;
        @(negedge clk);
        ifu_req = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk_zero("t5_rst");
        #1;
        base = ifu_rv_n + lsu_rv_n;
        repeat (6) @(negedge clk);
        #1;
        chk("t5_no_rv", ifu_rv_n + lsu_rv_n - base, 0);
        chk("t5_idle", o_mem_valid, 1'b0);
        rsp_gap = 0;
        ifu_addr = 32'h8000_0000;
        ifu_req = 1'b1;
        @(negedge clk);
        chk("t5_gnt", o_ifu_gnt, 1'b1);
        ifu_req = 1'b0;
        wait_pulse(0, cyc);
        chk("t5_data", o_ifu_rdata, 32'h0000_0413);

        // rvalid in the same cycle the timeout expires: data wins, no error
        base = err_n;
        rsp_gap = 7;
        lsu_wen = 1'b0; lsu_addr = 32'h8000_4000;
        lsu_req = 1'b1;
        @(negedge clk);
        lsu_req = 1'b0;
        wait_pulse(1, cyc);
        chk("t6_lat", cyc, 9);
        chk("t6_resp", {o_err, o_lsu_rdata}, {1'b0, word(32'h8000_4000)});
        #1;
        chk("t6_err_cnt", err_n - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
